sdram_address_sequencer: RTL and testbench
==========================================

Name: sdram_address_sequencer

Overview:
- Parametrised successor to the SDRAM read-address traverser.
- Keeps independent write and read pointers over the SDRAM space and presents both as bank/row/column fields.
- Treats the SDRAM as a circular buffer: tracks fill level, full/empty and error flags.
- Supports a selectable traversal order (row-major or bank-interleaved).
- Sits between the sensor-data write path and the downlink read path, ahead of the SDRAM controller command logic.

Parameters:
- BA_W, 2, bank address width (4 banks).
- ROW_W, 13, row address width (8192 rows).
- COL_W, 9, column address width (512 columns).
- BURST_LOG2, 0, log2 of words per step. A step advances the column by 2^BURST_LOG2. Legal range 0..COL_W.
- ORDER, 0, traversal order:
  - 0 = column, then row, then bank.
  - 1 = column, then bank, then row (bank-interleaved).

Ports:
- CLK_48MHZ  in  1  system clock, all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- CLEAR  in  1  synchronous pointer/flag clear.
- WR_NEXT  in  1  request to advance the write pointer one step.
- RD_NEXT  in  1  request to advance the read pointer one step.
- BA_WRITE_OUT  out  BA_W  current write bank.
- ROW_WRITE_OUT  out  ROW_W  current write row.
- COL_WRITE_OUT  out  COL_W  current write column.
- BA_READ_OUT  out  BA_W  current read bank.
- ROW_READ_OUT  out  ROW_W  current read row.
- COL_READ_OUT  out  COL_W  current read column.
- WR_ACK  out  1  one-cycle pulse: write step accepted.
- RD_ACK  out  1  one-cycle pulse: read step accepted.
- FULL  out  1  FILL_COUNT == DEPTH.
- EMPTY  out  1  FILL_COUNT == 0.
- FILL_COUNT  out  SW+1  occupied steps.
- ERR  out  1  sticky: write attempted while full (not set in overwrite mode), or read attempted while empty.

Behaviour:
- Definitions:
  - AW = BA_W + ROW_W + COL_W.
  - SW = AW − BURST_LOG2.
  - DEPTH = 2^SW.
- Pointers:
  - Each pointer is an SW-bit step counter.
  - Address fields are decoded combinationally from the registered counter, so outputs change the cycle after an accepted step.
  - Column low BURST_LOG2 bits are always 0.
  - ORDER=0: linear = {BA, ROW, COL}.
  - ORDER=1: linear = {ROW, BA, COL}.
- Wrap-around: a counter at DEPTH−1 steps to 0, i.e. the last column of the last row/bank returns to bank 0, row 0, column 0. Addressing is a full circular buffer.
- Reset (asynchronous):
  - Both pointers 0.
  - FILL_COUNT 0, EMPTY 1, FULL 0.
  - WR_ACK 0, RD_ACK 0, ERR 0.
- CLEAR (synchronous):
  - Same effect as reset on the next edge.
  - Has priority over WR_NEXT/RD_NEXT in the same cycle; those requests are dropped with no ACK.
- Write acceptance: WR_NEXT is accepted when not FULL, or when FULL and RD_NEXT is accepted in the same cycle.
- Read acceptance: RD_NEXT is accepted when not EMPTY.
- Simultaneous requests:
  - Not empty, not full: both accepted, FILL_COUNT unchanged.
  - EMPTY with both: only the write is accepted; FILL_COUNT becomes 1; ERR is set by the rejected read.
  - FULL with both: both accepted; count stays DEPTH.
- FILL_COUNT: +1 on write-only, −1 on read-only. Never exceeds DEPTH or drops below 0.
- ACKs: WR_ACK/RD_ACK are registered and high for exactly one cycle after each accepted step. Back-to-back requests each produce an ACK.
- ERR: sticky until RESET or CLEAR. A rejected request does not move its pointer.
- Reset mid-operation: async assertion forces all outputs to reset values immediately, regardless of pending requests.

Optional Feature:
- Macro ADDR_SEQ_OVERWRITE_EN.
- Defined: WR_NEXT while FULL (without an accepted read) is always accepted.
  - Write pointer advances.
  - Read pointer is force-advanced by one step, dropping the oldest entry.
  - FILL_COUNT stays DEPTH.
  - WR_ACK pulses, RD_ACK does not.
  - ERR is not set by this event.
  - Additional output OVERRUN (1 bit) is set sticky, cleared by RESET/CLEAR.
- Not defined: write while full is rejected and sets ERR; the OVERRUN port does not exist.

Test Plan:
- Reset and defaults: BA_W=1, ROW_W=2, COL_W=2 (DEPTH 32); assert RESET mid-cycle → all addresses 0, EMPTY=1, FILL_COUNT=0, ERR=0 immediately.
- Fill to full: 32 WR_NEXT pulses, ORDER=0.
  - After pulse 4: COL_WRITE_OUT=0, ROW_WRITE_OUT=1.
  - After pulse 16: BA_WRITE_OUT=1.
  - After pulse 32: FULL=1, FILL_COUNT=32, write address wrapped to 0/0/0.
  - 33rd WR_NEXT → no WR_ACK, ERR=1.
- ORDER=1 interleave: 8 writes → after pulse 4 BA_WRITE_OUT=1, ROW_WRITE_OUT=0; after pulse 8 BA=0, ROW=1.
- Simultaneous requests:
  - EMPTY with WR_NEXT=RD_NEXT=1 → only WR_ACK, FILL_COUNT=1, ERR=1.
  - FULL with both → both ACK, FILL_COUNT=32, both pointers +1.
- BURST_LOG2=1, DEPTH 16: 3 writes → COL_WRITE_OUT sequence 0, 2, 0 with ROW incrementing to 1; 2 reads → RD address 0/0/2 then 0/1/0, FILL_COUNT=1.
- CLEAR priority and overwrite:
  - CLEAR with WR_NEXT=1 → no ACK, all state zeroed.
  - With ADDR_SEQ_OVERWRITE_EN, write at FULL → read pointer +1, OVERRUN=1, ERR=0.

Source files
------------

// File: rtl/sdram_address_sequencer.sv
// Circular-buffer write/read address sequencer for SDRAM, decoded as bank/row/column fields.
// Define ADDR_SEQ_OVERWRITE_EN to let writes at FULL drop the oldest entry (adds OVERRUN).
module sdram_address_sequencer #(
  parameter int unsigned BA_W       = 2,
  parameter int unsigned ROW_W      = 13,
  parameter int unsigned COL_W      = 9,
  parameter int unsigned BURST_LOG2 = 0,
  parameter int unsigned ORDER      = 0
) (
  input  logic                                       CLK_48MHZ,
  input  logic                                       RESET,
  input  logic                                       CLEAR,
  input  logic                                       WR_NEXT,
  input  logic                                       RD_NEXT,
  output logic [BA_W-1:0]                            BA_WRITE_OUT,
  output logic [ROW_W-1:0]                           ROW_WRITE_OUT,
  output logic [COL_W-1:0]                           COL_WRITE_OUT,
  output logic [BA_W-1:0]                            BA_READ_OUT,
  output logic [ROW_W-1:0]                           ROW_READ_OUT,
  output logic [COL_W-1:0]                           COL_READ_OUT,
  output logic                                       WR_ACK,
  output logic                                       RD_ACK,
  output logic                                       FULL,
  output logic                                       EMPTY,
  output logic [BA_W+ROW_W+COL_W-BURST_LOG2:0]       FILL_COUNT,
`ifdef ADDR_SEQ_OVERWRITE_EN
  output logic                                       OVERRUN,
`endif
  output logic                                       ERR
);

  localparam int unsigned AW = BA_W + ROW_W + COL_W;
  localparam int unsigned SW = AW - BURST_LOG2;
  localparam logic [SW:0] DEPTH = {1'b1, {SW{1'b0}}};

  logic [SW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [SW:0]   count_q, count_d;
  logic          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic          err_q, err_d;
  logic          full, empty, wr_acc, rd_acc, force_rd;
`ifdef ADDR_SEQ_OVERWRITE_EN
  logic          overrun_q, overrun_d;
`endif

  function automatic logic [AW-1:0] to_linear(input logic [SW-1:0] ptr);
    return AW'(ptr) << BURST_LOG2;
  endfunction

  logic [AW-1:0] wr_lin, rd_lin;
  assign wr_lin = to_linear(wr_q);
  assign rd_lin = to_linear(rd_q);

  assign COL_WRITE_OUT = wr_lin[COL_W-1:0];
  assign COL_READ_OUT  = rd_lin[COL_W-1:0];

  if (ORDER == 0) begin : g_row_major
    assign BA_WRITE_OUT  = wr_lin[AW-1 -: BA_W];
    assign ROW_WRITE_OUT = wr_lin[COL_W +: ROW_W];
    assign BA_READ_OUT   = rd_lin[AW-1 -: BA_W];
    assign ROW_READ_OUT  = rd_lin[COL_W +: ROW_W];
  end else begin : g_bank_interleaved
    assign ROW_WRITE_OUT = wr_lin[AW-1 -: ROW_W];
    assign BA_WRITE_OUT  = wr_lin[COL_W +: BA_W];
    assign ROW_READ_OUT  = rd_lin[AW-1 -: ROW_W];
    assign BA_READ_OUT   = rd_lin[COL_W +: BA_W];
  end

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  always_comb begin
    rd_acc = RD_NEXT && !empty;
`ifdef ADDR_SEQ_OVERWRITE_EN
    wr_acc   = WR_NEXT;
    // Write into a full buffer without a concurrent read evicts the oldest entry.
    force_rd = WR_NEXT && full && !rd_acc;
`else
    wr_acc   = WR_NEXT && (!full || rd_acc);
    force_rd = 1'b0;
`endif

    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q;
    wr_ack_d = wr_acc;
    rd_ack_d = rd_acc;
    err_d    = err_q | (WR_NEXT && !wr_acc) | (RD_NEXT && !rd_acc);
`ifdef ADDR_SEQ_OVERWRITE_EN
    overrun_d = overrun_q | force_rd;
`endif

    if (wr_acc) wr_d = wr_q + SW'(1);
    if (rd_acc || force_rd) rd_d = rd_q + SW'(1);
    if (wr_acc && !rd_acc && !force_rd) begin
      count_d = count_q + (SW + 1)'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - (SW + 1)'(1);
    end

    if (CLEAR) begin
      wr_d     = '0;
      rd_d     = '0;
      count_d  = '0;
      wr_ack_d = 1'b0;
      rd_ack_d = 1'b0;
      err_d    = 1'b0;
`ifdef ADDR_SEQ_OVERWRITE_EN
      overrun_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef ADDR_SEQ_OVERWRITE_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      err_q    <= err_d;
`ifdef ADDR_SEQ_OVERWRITE_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign WR_ACK     = wr_ack_q;
  assign RD_ACK     = rd_ack_q;
  assign ERR        = err_q;
  assign FULL       = full;
  assign EMPTY      = empty;
  assign FILL_COUNT = count_q;
`ifdef ADDR_SEQ_OVERWRITE_EN
  assign OVERRUN    = overrun_q;
`endif

endmodule

// File: tb/tb_sdram_address_sequencer.sv
// Directed bench for sdram_address_sequencer: three small instances cover ORDER=0, ORDER=1
// and BURST_LOG2=1 with DEPTH 32/32/16.
module tb_sdram_address_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0, wr2 = 1'b0, rd2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u0: ORDER=0, BURST_LOG2=0
  logic       ba_w0, ba_r0, wack0, rack0, full0, empty0, err0;
  logic [1:0] row_w0, col_w0, row_r0, col_r0;
  logic [5:0] cnt0;
`ifdef ADDR_SEQ_OVERWRITE_EN
  logic       ovr0, ovr1, ovr2;
`endif

  sdram_address_sequencer #(.BA_W(1), .ROW_W(2), .COL_W(2), .BURST_LOG2(0), .ORDER(0)) u0 (
    .CLK_48MHZ(clk), .RESET(rst), .CLEAR(clr), .WR_NEXT(wr0), .RD_NEXT(rd0),
    .BA_WRITE_OUT(ba_w0), .ROW_WRITE_OUT(row_w0), .COL_WRITE_OUT(col_w0),
    .BA_READ_OUT(ba_r0), .ROW_READ_OUT(row_r0), .COL_READ_OUT(col_r0),
    .WR_ACK(wack0), .RD_ACK(rack0), .FULL(full0), .EMPTY(empty0), .FILL_COUNT(cnt0),
`ifdef ADDR_SEQ_OVERWRITE_EN
    .OVERRUN(ovr0),
`endif
    .ERR(err0)
  );

  // u1: ORDER=1 (bank-interleaved)
  logic       ba_w1, ba_r1, wack1, rack1, full1, empty1, err1;
  logic [1:0] row_w1, col_w1, row_r1, col_r1;
  logic [5:0] cnt1;

  sdram_address_sequencer #(.BA_W(1), .ROW_W(2), .COL_W(2), .BURST_LOG2(0), .ORDER(1)) u1 (
    .CLK_48MHZ(clk), .RESET(rst), .CLEAR(clr), .WR_NEXT(wr1), .RD_NEXT(rd1),
    .BA_WRITE_OUT(ba_w1), .ROW_WRITE_OUT(row_w1), .COL_WRITE_OUT(col_w1),
    .BA_READ_OUT(ba_r1), .ROW_READ_OUT(row_r1), .COL_READ_OUT(col_r1),
    .WR_ACK(wack1), .RD_ACK(rack1), .FULL(full1), .EMPTY(empty1), .FILL_COUNT(cnt1),
`ifdef ADDR_SEQ_OVERWRITE_EN
    .OVERRUN(ovr1),
`endif
    .ERR(err1)
  );

  // u2: ORDER=0, BURST_LOG2=1
  logic       ba_w2, ba_r2, wack2, rack2, full2, empty2, err2;
  logic [1:0] row_w2, col_w2, row_r2, col_r2;
  logic [4:0] cnt2;

  sdram_address_sequencer #(.BA_W(1), .ROW_W(2), .COL_W(2), .BURST_LOG2(1), .ORDER(0)) u2 (
    .CLK_48MHZ(clk), .RESET(rst), .CLEAR(clr), .WR_NEXT(wr2), .RD_NEXT(rd2),
    .BA_WRITE_OUT(ba_w2), .ROW_WRITE_OUT(row_w2), .COL_WRITE_OUT(col_w2),
    .BA_READ_OUT(ba_r2), .ROW_READ_OUT(row_r2), .COL_READ_OUT(col_r2),
    .WR_ACK(wack2), .RD_ACK(rack2), .FULL(full2), .EMPTY(empty2), .FILL_COUNT(cnt2),
`ifdef ADDR_SEQ_OVERWRITE_EN
    .OVERRUN(ovr2),
`endif
    .ERR(err2)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr0 = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({ba_w0, row_w0, col_w0} !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", {ba_w0, row_w0, col_w0}); end
    n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty0); end
    n_checks++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    n_checks++; if ({err0, wack0, full0} !== 3'b000) begin n_fail++; $display("FAIL reset_err_ack_full: got %b expected 000", {err0, wack0, full0}); end
    tick();
    wr0 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    int acks = 0;
    wr0 = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (wack0 === 1'b1) acks++;
      if (i == 4) begin
        n_checks++; if ({row_w0, col_w0} !== 4'b01_00) begin n_fail++; $display("FAIL fill_p4: got row %0d col %0d expected row 1 col 0", row_w0, col_w0); end
      end
      if (i == 16) begin
        n_checks++; if ({ba_w0, row_w0, col_w0} !== 5'b1_00_00) begin n_fail++; $display("FAIL fill_p16: got %b expected 10000", {ba_w0, row_w0, col_w0}); end
      end
    end
    n_checks++; if (acks != 32) begin n_fail++; $display("FAIL fill_acks: got %0d expected 32", acks); end
    n_checks++; if ({full0, empty0} !== 2'b10) begin n_fail++; $display("FAIL fill_full: got %b expected 10", {full0, empty0}); end
    n_checks++; if (cnt0 !== 6'd32) begin n_fail++; $display("FAIL fill_count: got %0d expected 32", cnt0); end
    n_checks++; if ({ba_w0, row_w0, col_w0} !== 5'd0) begin n_fail++; $display("FAIL fill_wrap: got %0d expected 0", {ba_w0, row_w0, col_w0}); end
    n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL fill_no_err: got %b expected 0", err0); end
    tick();
    wr0 = 1'b0;
    n_checks++; if ({wack0, err0} !== 2'b01) begin n_fail++; $display("FAIL write_when_full: got ack/err %b expected 01", {wack0, err0}); end
    n_checks++; if (cnt0 !== 6'd32) begin n_fail++; $display("FAIL full_count_hold: got %0d expected 32", cnt0); end
  endtask

  task automatic test_simul_full();
    wr0 = 1'b1; rd0 = 1'b1;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
    n_checks++; if ({wack0, rack0} !== 2'b11) begin n_fail++; $display("FAIL simul_full_acks: got %b expected 11", {wack0, rack0}); end
    n_checks++; if (cnt0 !== 6'd32) begin n_fail++; $display("FAIL simul_full_count: got %0d expected 32", cnt0); end
    n_checks++; if ({col_w0, col_r0} !== 4'b01_01) begin n_fail++; $display("FAIL simul_full_ptrs: got wr col %0d rd col %0d expected 1 1", col_w0, col_r0); end
    tick();
    n_checks++; if ({wack0, rack0} !== 2'b00) begin n_fail++; $display("FAIL ack_one_cycle: got %b expected 00", {wack0, rack0}); end
  endtask

  task automatic test_clear();
    clr = 1'b1; wr0 = 1'b1;
    tick();
    clr = 1'b0; wr0 = 1'b0;
    n_checks++; if (wack0 !== 1'b0) begin n_fail++; $display("FAIL clear_no_ack: got %b expected 0", wack0); end
    n_checks++; if ({cnt0, empty0, err0} !== {6'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL clear_state: got count %0d empty %b err %b expected 0 1 0", cnt0, empty0, err0); end
    n_checks++; if ({col_w0, col_r0, row_w0} !== 6'd0) begin n_fail++; $display("FAIL clear_ptrs: got %b expected 000000", {col_w0, col_r0, row_w0}); end
  endtask

  task automatic test_simul_empty();
    wr0 = 1'b1; rd0 = 1'b1;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
    n_checks++; if ({wack0, rack0} !== 2'b10) begin n_fail++; $display("FAIL simul_empty_acks: got %b expected 10", {wack0, rack0}); end
    n_checks++; if (cnt0 !== 6'd1) begin n_fail++; $display("FAIL simul_empty_count: got %0d expected 1", cnt0); end
    n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL simul_empty_err: got %b expected 1", err0); end
    n_checks++; if ({col_w0, col_r0} !== 4'b01_00) begin n_fail++; $display("FAIL simul_empty_ptrs: got wr col %0d rd col %0d expected 1 0", col_w0, col_r0); end
  endtask

  task automatic test_overwrite();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wr0 = 1'b1;
    repeat (32) tick();
    tick();
    wr0 = 1'b0;
    n_checks++; if (cnt0 !== 6'd32) begin n_fail++; $display("FAIL overwrite_count: got %0d expected 32", cnt0); end
`ifdef ADDR_SEQ_OVERWRITE_EN
    n_checks++; if ({wack0, rack0} !== 2'b10) begin n_fail++; $display("FAIL overwrite_acks: got %b expected 10", {wack0, rack0}); end
    n_checks++; if ({col_w0, col_r0} !== 4'b01_01) begin n_fail++; $display("FAIL overwrite_ptrs: got wr col %0d rd col %0d expected 1 1", col_w0, col_r0); end
    n_checks++; if ({ovr0, err0} !== 2'b10) begin n_fail++; $display("FAIL overwrite_flags: got overrun/err %b expected 10", {ovr0, err0}); end
`else
    n_checks++; if ({wack0, err0} !== 2'b01) begin n_fail++; $display("FAIL reject_full: got ack/err %b expected 01", {wack0, err0}); end
    n_checks++; if ({col_w0, col_r0} !== 4'b00_00) begin n_fail++; $display("FAIL reject_ptrs: got wr col %0d rd col %0d expected 0 0", col_w0, col_r0); end
`endif
  endtask

  task automatic test_interleave();
    wr1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) begin
        n_checks++; if ({ba_w1, row_w1, col_w1} !== 5'b1_00_00) begin n_fail++; $display("FAIL ilv_p4: got ba %0d row %0d col %0d expected 1 0 0", ba_w1, row_w1, col_w1); end
      end
    end
    wr1 = 1'b0;
    n_checks++; if ({ba_w1, row_w1, col_w1} !== 5'b0_01_00) begin n_fail++; $display("FAIL ilv_p8: got ba %0d row %0d col %0d expected 0 1 0", ba_w1, row_w1, col_w1); end
    n_checks++; if ({cnt1, err1} !== {6'd8, 1'b0}) begin n_fail++; $display("FAIL ilv_count: got %0d err %b expected 8 0", cnt1, err1); end
  endtask

  task automatic test_burst();
    logic [1:0] exp_col [3];
    logic [1:0] exp_row [3];
    exp_col[0] = 2'd0; exp_col[1] = 2'd2; exp_col[2] = 2'd0;
    exp_row[0] = 2'd0; exp_row[1] = 2'd0; exp_row[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({row_w2, col_w2} !== {exp_row[i], exp_col[i]}) begin n_fail++; $display("FAIL burst_wr%0d: got row %0d col %0d expected %0d %0d", i, row_w2, col_w2, exp_row[i], exp_col[i]); end
      wr2 = 1'b1;
      tick();
      wr2 = 1'b0;
    end
    rd2 = 1'b1;
    tick();
    n_checks++; if ({ba_r2, row_r2, col_r2} !== 5'b0_00_10) begin n_fail++; $display("FAIL burst_rd1: got %b expected 00010", {ba_r2, row_r2, col_r2}); end
    tick();
    rd2 = 1'b0;
    n_checks++; if ({ba_r2, row_r2, col_r2} !== 5'b0_01_00) begin n_fail++; $display("FAIL burst_rd2: got %b expected 00100", {ba_r2, row_r2, col_r2}); end
    n_checks++; if (cnt2 !== 5'd1) begin n_fail++; $display("FAIL burst_count: got %0d expected 1", cnt2); end
  endtask

  initial begin
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_fill();
    test_simul_full();
    test_clear();
    test_simul_empty();
    test_overwrite();
    test_interleave();
    test_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
